hazard_stall_ctrl: RTL and testbench

- Pipeline front-end controller for the 5-stage MIPS32 core.
- Drives the IF/ID register's write-enable and flush, the PC write-enable, and the ID/EX bubble-insert.
- Resolves three hazard sources:
  - load-use data hazard: 1-cycle stall;
  - taken branch/jump resolved in EX: flush;
  - multi-cycle multiply/divide occupancy: MDU_LAT-1 cycle freeze, tracked by a small FSM and down-counter.
- Sits in ID, beside the IF/ID and ID/EX registers.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_perf_cnt.sv | 29 ++
 rtl/hazard_stall_ctrl_chk.sv | 18 +
 rtl/hazard_stall_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard/stall controller.
//   state_t   : controller FSM state (RUN, MDU_WAIT)
//   DEF_REG_W : default register-specifier width
//   ZERO_REG  : architectural $zero specifier; loads to it never create a hazard
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam int DEF_REG_W = 5;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit saturating event counter with synchronous clear.
// Ports:
//   clk   in   clock
//   reset in   asynchronous, active-high reset (count -> 0)
//   clr   in   synchronous clear, wins over inc
//   inc   in   count one event this cycle
//   count out  current count, sticks at 32'hFFFF_FFFF
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (clr) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl_chk.sv
// hazard_stall_ctrl_chk: simulation-only protocol checks for hazard_stall_ctrl.
// Ports:
//   clk, reset   in  clock / asynchronous active-high reset
//   mdu_busy     in  controller is in MDU_WAIT
//   branch_taken in  EX resolved a taken branch/jump
module hazard_stall_ctrl_chk (
    input  logic clk,
    input  logic reset,
    input  logic mdu_busy,
    input  logic branch_taken
);

    // EX holds the MDU op or bubbles while waiting, so no branch can resolve.
    a_no_branch_in_wait: assert property (
        @(posedge clk) disable iff (reset) !(mdu_busy && branch_taken)
    ) else $error("branch_taken asserted while MDU_WAIT");

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard controller for the 5-stage MIPS32 core.
// Handles load-use stalls (1 bubble), EX-resolved taken branch flushes and
// multi-cycle mult/div occupancy (MDU_LAT-1 frozen cycles).
// Outputs are combinational from state/cnt and current inputs.
// Parameters: MDU_LAT (1..8), REG_W, CNT_W (2^CNT_W >= MDU_LAT).
// Ports:
//   clk, reset                       clock / asynchronous active-high reset
//   ifid_valid, ifid_rs, ifid_rt     instruction in ID and its source fields
//   ifid_uses_rt, ifid_mdu           ID reads rt / ID is mult/div
//   idex_valid, idex_memread, idex_rt  instruction in EX (load + destination)
//   branch_taken                     EX resolved a taken branch/jump
//   pc_write, if_id_write            PC / IF/ID load enables
//   if_id_flush, id_ex_flush         IF/ID clear / ID/EX bubble insert
//   mdu_busy                         FSM is in MDU_WAIT
// Optional (macro HAZARD_PERF_EN): perf_clr in, perf_stall_cnt / perf_flush_cnt out.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int REG_W   = DEF_REG_W,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ifid_valid,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_mdu,
    input  logic             idex_valid,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mdu_busy
`ifdef HAZARD_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam logic [REG_W-1:0] ZERO_RT   = REG_W'(ZERO_REG);
    localparam logic             MDU_MULTI = 1'((MDU_LAT > 1) ? 1 : 0);
    // Wait length is cnt load + 1, giving MDU_LAT-1 frozen cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             lu_s;

    // Load-use detection; $zero destinations never hazard.
    always_comb begin
        lu_s = ifid_valid & idex_valid & idex_memread & (idex_rt != ZERO_RT) &
               ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
    end

    // FSM state and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and output decode; reset forces every enable low.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mdu_busy    = 1'b0;
        if (reset) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (branch_taken) begin
                        // Flush wins over any concurrent stall source.
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (lu_s) begin
                        // Single bubble: next cycle the load is in MEM.
                        id_ex_flush = 1'b1;
                    end else if (ifid_valid && ifid_mdu && MDU_MULTI) begin
                        // MDU op advances into EX now, then freeze the front end.
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        state_nxt_s = MDU_WAIT;
                        cnt_nxt_s   = CNT_LOAD;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    id_ex_flush = 1'b1;
                    mdu_busy    = 1'b1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    hazard_stall_ctrl_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .mdu_busy     (mdu_busy),
        .branch_taken (branch_taken)
    );

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .inc   (~pc_write & ~reset),
        .count (perf_stall_cnt)
    );

    hazard_perf_cnt u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .inc   (if_id_flush),
        .count (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MDU_LAT=4). The stimulus process
// drives one input vector per cycle and queues the hand-computed output word
// {pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy}; a monitor
// pops and compares on the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [4:0] ZERO  = 5'b00000;
    localparam logic [4:0] ADV   = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] WAITC = 5'b00011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ifid_valid = 1'b0;
    logic [4:0] ifid_rs = 5'd0;
    logic [4:0] ifid_rt = 5'd0;
    logic       ifid_uses_rt = 1'b0;
    logic       ifid_mdu = 1'b0;
    logic       idex_valid = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rt = 5'd0;
    logic       branch_taken = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy;
`ifdef HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    string      name_q[$];

    hazard_stall_ctrl #(.MDU_LAT(4), .REG_W(5), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ifid_valid   (ifid_valid),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .ifid_mdu     (ifid_mdu),
        .idex_valid   (idex_valid),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mdu_busy     (mdu_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        logic [4:0] got;
        logic [4:0] exp;
        string      nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b (pc,ifw,iff,idf,busy)", nm, got, exp);
            end
        end
    end

    task automatic step(input logic rst, input logic iv, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic md,
                        input logic xv, input logic mr, input logic [4:0] xrt,
                        input logic br, input logic [4:0] exp, input string nm);
        @(posedge clk);
        #1;
        reset        = rst;
        ifid_valid   = iv;
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_uses_rt = urt;
        ifid_mdu     = md;
        idex_valid   = xv;
        idex_memread = mr;
        idex_rt      = xrt;
        branch_taken = br;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [4:0] exp, input string nm);
        step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, exp, nm);
    endtask

`ifdef HAZARD_PERF_EN
    task automatic perf_check(input logic [31:0] es, input logic [31:0] ef, input string nm);
        @(negedge clk);
        #2;
        checks++;
        if (perf_stall_cnt !== es || perf_flush_cnt !== ef) begin
            errors++;
            $display("FAIL %s: stall %0d flush %0d expected %0d %0d", nm,
                     perf_stall_cnt, perf_flush_cnt, es, ef);
        end
    endtask
`endif

    initial begin
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ZERO, "reset_0");
        step(1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, ZERO, "reset_1");
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b1;
`endif
        idle(ADV, "idle");
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b0;
`endif
        // Load-use on rs, then the load moves on.
        step(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, STALL, "lu_rs");
        step(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ADV, "lu_after");
        // Branch beats a concurrent load-use.
        step(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, FLUSH, "br_lu");
        // MDU issue then exactly 3 wait cycles (lu inputs ignored in wait).
        step(1'b0, 1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, ADV, "mdu_issue");
        step(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, WAITC, "mdu_wait1");
        idle(WAITC, "mdu_wait2");
        idle(WAITC, "mdu_wait3");
        idle(ADV, "mdu_done");
`ifdef HAZARD_PERF_EN
        perf_check(32'd4, 32'd1, "perf_counts");
        perf_clr = 1'b1;
        idle(ADV, "perf_clr_cyc");
        perf_clr = 1'b0;
        perf_check(32'd0, 32'd0, "perf_cleared");
`endif
        // Load-use on rt, and rt match without rt use.
        step(1'b0, 1'b1, 5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, STALL, "lu_rt");
        step(1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, ADV, "lu_rt_unused");
        // Load to $0 never stalls.
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, ADV, "lu_zero");
        // Invalid ID suppresses both lu and MDU detection.
        step(1'b0, 1'b0, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, ADV, "lu_novalid");
        step(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, ADV, "mdu_novalid");
        idle(ADV, "mdu_novalid_next");
        // Branch with an MDU in ID: no wait follows.
        step(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, FLUSH, "br_mdu");
        idle(ADV, "br_mdu_next");
        // Back-to-back mult: ID holds the second one through the first wait.
        step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, ADV, "b2b_issue1");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, WAITC, "b2b_wait1");
        end
        step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, ADV, "b2b_issue2");
        for (int i = 0; i < 3; i++) begin
            idle(WAITC, "b2b_wait2");
        end
        idle(ADV, "b2b_done");
        // Reset in the 2nd wait cycle, then normal advance.
        step(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, ADV, "rst_issue");
        idle(WAITC, "rst_wait1");
        step(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, ZERO, "rst_mid");
        idle(ADV, "rst_release");
        idle(ADV, "rst_release2");

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
